// File: rtl/imem_loader.sv
// Purpose: loads a framed byte stream (SYNC, N lo, N hi, 4*N bytes) into instruction memory.
// Latency: one mem write strobe in the cycle after the 4th byte of each word is accepted.
// Backpressure: rx_ready_o drops only in the write cycle; ERR and RUN keep discarding bytes.
// Ports: clk_i/rst_ni (sync, active-low) | rx_data_i/rx_valid_i/rx_ready_o byte stream in |
//        mem_we_o/mem_addr_o/mem_wdata_o word writes out | core_rst_o, busy_o, err_o status.
// All outputs are registered and derived from the next state, so they track state_q exactly.
module imem_loader #(
  parameter int         DEPTH_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    ST_SYNC, ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_RUN, ST_ERR
  } state_e;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [23:0] asm_q, asm_d;      // first three bytes of the word being assembled
  logic        rx_ready_q, rx_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        core_rst_q, core_rst_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        acc;
  logic [15:0] n_full;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    asm_d       = asm_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    acc    = rx_valid_i & rx_ready_q;
    n_full = {rx_data_i, len_q[7:0]};

    case (state_q)
      ST_SYNC: begin
        if (acc && rx_data_i == SYNC_BYTE) state_d = ST_LEN0;
      end
      ST_LEN0: begin
        if (acc) begin
          len_d[7:0] = rx_data_i;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (acc) begin
          len_d = n_full;
          if (n_full == 16'd0) begin
            state_d = ST_RUN;
          end else if ({1'b0, n_full} > DEPTH_L) begin
            state_d = ST_ERR;
          end else begin
            byte_cnt_d = 2'd0;
            word_cnt_d = 16'd0;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (acc) begin
          // Little-endian: earliest byte ends up in the low lane.
          asm_d      = {rx_data_i, asm_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d     = ST_WRITE;
            mem_addr_d  = {14'd0, word_cnt_q, 2'b00};
            mem_wdata_d = {rx_data_i, asm_q};
          end
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = (word_cnt_d == len_q) ? ST_RUN : ST_DATA;
      end
      ST_RUN: begin
        if (acc && rx_data_i == SYNC_BYTE) state_d = ST_LEN0;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: state_d = ST_SYNC;
    endcase

    // Status flags are a pure function of the state being entered.
    rx_ready_d = (state_d != ST_WRITE);
    mem_we_d   = (state_d == ST_WRITE);
    core_rst_d = (state_d != ST_RUN);
    busy_d     = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                 (state_d == ST_DATA) || (state_d == ST_WRITE);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_SYNC;
      len_q       <= 16'd0;
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= 16'd0;
      asm_q       <= 24'd0;
      rx_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      asm_q       <= asm_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign core_rst_o  = core_rst_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: directed bench for imem_loader; drives framed byte streams and checks writes/status.
// Latency: byte driver waits on rx_ready_o, write monitor samples on the falling edge.
// Backpressure: driver holds rx_valid through stall cycles; every wait is bounded.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        busy;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;
  int rdy_viol = 0;
  bit mon_en = 1'b0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(1024), .SYNC_BYTE(8'hA5)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .core_rst_o (core_rst),
    .busy_o     (busy),
    .err_o      (err)
  );

  // Capture every write pulse; ready must be low exactly while writing.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
      end
      if (mem_we == rx_ready) rdy_viol++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a byte and return 1 time unit after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check_eq("ready_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [31:0] ea, input logic [31:0] ed);
    if (idx < wa_q.size()) begin
      check_eq({tag, "_addr"}, wa_q[idx], ea);
      check_eq({tag, "_data"}, wd_q[idx], ed);
    end else begin
      check_eq({tag, "_missing"}, 32'(wa_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(posedge clk);
    do_reset();

    // Reset state
    check_eq("rst_ready", 32'(rx_ready), 32'd1);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_core_rst", 32'(core_rst), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // Two-word frame, valid held high
    send_byte(8'hA5);
    check_eq("t1_busy_after_sync", 32'(busy), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check_eq("t1_we_w0", 32'(mem_we), 32'd1);
    check_eq("t1_rdy_w0", 32'(rx_ready), 32'd0);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    check_eq("t1_we_w1", 32'(mem_we), 32'd1);
    check_eq("t1_core_rst_in_write", 32'(core_rst), 32'd1);
    check_eq("t1_busy_in_write", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check_eq("t1_core_rst_fall", 32'(core_rst), 32'd0);
    check_eq("t1_busy_fall", 32'(busy), 32'd0);
    check_eq("t1_we_after", 32'(mem_we), 32'd0);
    check_eq("t1_nwrites", 32'(wa_q.size()), 32'd2);
    check_write("t1_w0", 0, 32'h0, 32'h12345678);
    check_write("t1_w1", 1, 32'h4, 32'hDEADBEEF);

    // Reload from RUN with a one-word image
    wa_q.delete(); wd_q.delete();
    send_byte(8'h11);
    check_eq("t4_run_discard", 32'(core_rst), 32'd0);
    send_byte(8'hA5);
    check_eq("t4_core_rst_rise", 32'(core_rst), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    check_eq("t4_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    check_eq("t4_core_rst_fall", 32'(core_rst), 32'd0);
    check_eq("t4_nwrites", 32'(wa_q.size()), 32'd1);
    check_write("t4_w0", 0, 32'h0, 32'h11223344);

    // Zero-length frame with leading junk
    do_reset();
    send_byte(8'h00); send_byte(8'hFF);
    check_eq("t2_junk_busy", 32'(busy), 32'd0);
    send_byte(8'hA5);
    check_eq("t2_sync_core_rst", 32'(core_rst), 32'd1);
    send_byte(8'h00); send_byte(8'h00);
    check_eq("t2_core_rst_fall", 32'(core_rst), 32'd0);
    check_eq("t2_busy", 32'(busy), 32'd0);
    check_eq("t2_err", 32'(err), 32'd0);
    check_eq("t2_nwrites", 32'(wa_q.size()), 32'd0);

    // Oversized count goes to ERR
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
    check_eq("t3_err", 32'(err), 32'd1);
    check_eq("t3_core_rst", 32'(core_rst), 32'd1);
    check_eq("t3_busy", 32'(busy), 32'd0);
    check_eq("t3_ready", 32'(rx_ready), 32'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    @(posedge clk); #1;
    check_eq("t3_err_sticky", 32'(err), 32'd1);
    check_eq("t3_core_rst_held", 32'(core_rst), 32'd1);
    check_eq("t3_nwrites", 32'(wa_q.size()), 32'd0);
    do_reset();
    check_eq("t3_err_cleared", 32'(err), 32'd0);

    // Reset mid-frame
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    check_eq("t5_nwrites", 32'(wa_q.size()), 32'd1);
    check_write("t5_w0", 0, 32'h0, 32'h04030201);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_ready", 32'(rx_ready), 32'd1);
    check_eq("t5_we", 32'(mem_we), 32'd0);
    check_eq("t5_addr", mem_addr, 32'd0);
    check_eq("t5_wdata", mem_wdata, 32'd0);
    check_eq("t5_core_rst", 32'(core_rst), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    wa_q.delete(); wd_q.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h34); send_byte(8'h12);
    @(posedge clk); #1;
    check_eq("t5_reload_core_rst", 32'(core_rst), 32'd0);
    check_eq("t5_reload_n", 32'(wa_q.size()), 32'd1);
    check_write("t5_reload", 0, 32'h0, 32'h1234ABCD);

    // 16-word frame with random valid gaps; A5 appears as data
    do_reset();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
    for (int k = 0; k < 16; k++) begin
      w = {8'hA5, 8'(k), 8'(k * 3), ~8'(k)};
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 1) == 1) begin
          rx_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_byte(w[8*b +: 8]);
      end
    end
    @(posedge clk); #1;
    check_eq("t6_core_rst", 32'(core_rst), 32'd0);
    check_eq("t6_nwrites", 32'(wa_q.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      check_write($sformatf("t6_w%0d", k), k, 32'(4 * k),
                  {8'hA5, 8'(k), 8'(k * 3), ~8'(k)});
    end

    check_eq("ready_vs_we", 32'(rdy_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that writes a program image into the 32-bit instruction memory read by the CYBERcobra core and holds the core in reset while it does so. It accepts framed bytes over a valid/ready interface, assembles little-endian 32-bit words, and issues single-cycle word writes at consecutive byte addresses starting from 0. After the last word is written it releases the core reset, so the core fetches from PC = 0 on the next cycle.

## Interface
Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in 32-bit words; legal frame word count is 0..DEPTH_WORDS.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_ni  input  1  reset, synchronous and active-low.
- rx_data_i  input  8  incoming byte.
- rx_valid_i  input  1  rx_data_i valid.
- rx_ready_o  output  1  loader accepts a byte this cycle; a transfer occurs on an edge where rx_valid_i & rx_ready_o.
- mem_we_o  output  1  instruction memory write strobe, one cycle per word.
- mem_addr_o  output  32  byte address of the write, always word-aligned (bits [1:0] = 0).
- mem_wdata_o  output  32  write data.
- core_rst_o  output  1  active-high reset to the core; 1 while loading.
- busy_o  output  1  1 from the accepted SYNC_BYTE until the RUN or ERR state is entered.
- err_o  output  1  sticky frame error flag.

## Operation
- Frame: SYNC_BYTE, count low byte, count high byte (16-bit N, little-endian), then 4·N data bytes. Each group of four bytes forms a word {b3,b2,b1,b0}.
- Word k is written to mem_addr_o = 4·k, for k = 0..N-1.
- States:
  - SYNC: accept bytes. A byte equal to SYNC_BYTE moves to LEN0; any other byte is discarded.
  - LEN0: latch the count low byte, then go to LEN1.
  - LEN1: latch the count high byte. If N == 0, go to RUN. If N > DEPTH_WORDS, go to ERR. Otherwise clear the byte and word counters and go to DATA.
  - DATA: shift bytes into the assembly register. On the 4th byte go to WRITE.
  - WRITE: one cycle with mem_we_o = 1 and rx_ready_o = 0. Then increment the word counter: if it equals N, go to RUN; otherwise go to DATA.
  - RUN: core_rst_o = 0. An accepted SYNC_BYTE reasserts core_rst_o on the next cycle and goes to LEN0 (reload); other bytes are discarded.
  - ERR: err_o = 1, core_rst_o = 1, rx_ready_o = 1, and all bytes are discarded. Only rst_ni exits this state.
- Address and data registers are driven only in WRITE; mem_we_o is never asserted outside WRITE.
- Byte counter is 2 bits and wraps 3→0. Word counter is 16 bits; it cannot overflow because N ≤ DEPTH_WORDS is checked.
- A reload with a shorter image leaves the words above the new N unchanged.

## Timing
- All outputs are registered.
- Reset values: state = SYNC, rx_ready_o = 1, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, core_rst_o = 1, busy_o = 0, err_o = 0.
- Reset applied mid-frame returns to these values on the next edge. The partial image is abandoned and the memory contents written so far are not cleared.
- rx_ready_o is 1 in every state except WRITE, so every 4th data byte costs one stall cycle. Peak throughput is 4 bytes per 5 cycles.
- mem_we_o goes high in the cycle after the edge that accepts the 4th byte of a word.
- core_rst_o falls in the cycle after the final WRITE cycle, or in the cycle after LEN1 when N = 0.
- busy_o falls in that same cycle, or on entry to ERR.
- SYNC_BYTE values inside LEN or DATA are treated as ordinary data; there is no resynchronisation mid-frame.
- rx_valid_i held high through WRITE is not consumed; the byte is accepted on the next edge with rx_ready_o = 1.

## Test plan
- Reset, then send A5 02 00 78 56 34 12 EF BE AD DE with valid always high → two write pulses: addr 0x0 data 0x12345678, then addr 0x4 data 0xDEADBEEF. rx_ready_o is low exactly during each write cycle. core_rst_o falls one cycle after the second write; busy_o is 1 in between.
- Send 00 FF A5 00 00 → leading bytes are discarded, no writes occur, core_rst_o falls one cycle after the last count byte, and err_o stays 0.
- With DEPTH_WORDS = 1024, send A5 01 04 (N = 1025) → ERR state, err_o = 1, core_rst_o stays 1. Further bytes, including A5, are discarded; after rst_ni is pulsed low, err_o = 0.
- From RUN after a 2-word image, send A5 01 00 44 33 22 11 → core_rst_o rises one cycle after the A5 is accepted, then a single write of addr 0x0 data 0x11223344, then core_rst_o falls again.
- Send A5 03 00 and 6 data bytes, then assert rst_ni low for one cycle → exactly one write was issued, and all outputs show their reset values after the edge. A following full frame loads correctly.
- Toggle rx_valid_i randomly during a 16-word frame → 16 writes occur at addresses 0x0..0x3C in order, with data matching the byte stream and no extra or missing writes.
